// File: rtl/l2_request_arbiter.sv
// rtl/l2_request_arbiter.sv - round-robin arbiter sharing one L2 port between I-cache and D-cache queues
// Optional statistics counters are enabled by defining ARB_STATS_EN.
module l2_request_arbiter #(
    parameter int ADDR_W = 26,
    parameter int QDEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_req_ready,
    input  logic              d_req_valid,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_we,
    output logic              d_req_ready,
    output logic              l2_valid,
    output logic [ADDR_W-1:0] l2_addr,
    output logic              l2_we,
    output logic              l2_src,
    input  logic              l2_ready,
    input  logic              l2_done,
    output logic              i_done,
    output logic              d_done,
    output logic              busy
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]       i_grants,
    output logic [31:0]       d_grants,
    output logic [31:0]       wait_cycles
`endif
);
    localparam int AW = $clog2(QDEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] i_mem [QDEPTH];
    logic [ADDR_W:0]   d_mem [QDEPTH];
    logic [PW-1:0]     i_wr, i_rd, d_wr, d_rd;
    logic              i_empty, d_empty, i_full, d_full;
    logic              i_push, d_push, i_pop, d_pop;
    logic              last, pick;

    assign i_empty = (i_wr == i_rd);
    assign d_empty = (d_wr == d_rd);
    assign i_full  = (i_wr[AW] != i_rd[AW]) && (i_wr[AW-1:0] == i_rd[AW-1:0]);
    assign d_full  = (d_wr[AW] != d_rd[AW]) && (d_wr[AW-1:0] == d_rd[AW-1:0]);

    assign i_req_ready = !i_full;
    assign d_req_ready = !d_full;
    assign i_push = i_req_valid && !i_full;
    assign d_push = d_req_valid && !d_full;
    assign i_pop  = (state == ST_ISSUE) && l2_ready && !l2_src;
    assign d_pop  = (state == ST_ISSUE) && l2_ready && l2_src;
    assign busy   = (state != ST_IDLE) || !i_empty || !d_empty;

    // On contention the source that was not served last wins.
    assign pick = d_empty ? 1'b0 : (i_empty ? 1'b1 : !last);

    always_ff @(posedge clk) begin
        if (i_push) i_mem[i_wr[AW-1:0]] <= i_req_addr;
        if (d_push) d_mem[d_wr[AW-1:0]] <= {d_req_we, d_req_addr};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_wr <= '0;
            i_rd <= '0;
            d_wr <= '0;
            d_rd <= '0;
        end else begin
            if (i_push) i_wr <= i_wr + PTR_ONE;
            if (i_pop)  i_rd <= i_rd + PTR_ONE;
            if (d_push) d_wr <= d_wr + PTR_ONE;
            if (d_pop)  d_rd <= d_rd + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            last     <= 1'b1;
            l2_valid <= 1'b0;
            l2_addr  <= '0;
            l2_we    <= 1'b0;
            l2_src   <= 1'b0;
            i_done   <= 1'b0;
            d_done   <= 1'b0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!i_empty || !d_empty) begin
                        l2_src   <= pick;
                        l2_valid <= 1'b1;
                        if (pick) begin
                            {l2_we, l2_addr} <= d_mem[d_rd[AW-1:0]];
                        end else begin
                            l2_addr <= i_mem[i_rd[AW-1:0]];
                            l2_we   <= 1'b0;
                        end
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (l2_ready) begin
                        l2_valid <= 1'b0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (l2_done) begin
                        if (l2_src) d_done <= 1'b1;
                        else        i_done <= 1'b1;
                        last  <= l2_src;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_grants    <= '0;
            d_grants    <= '0;
            wait_cycles <= '0;
        end else begin
            if (i_pop && (i_grants != 32'hFFFF_FFFF)) i_grants <= i_grants + 32'd1;
            if (d_pop && (d_grants != 32'hFFFF_FFFF)) d_grants <= d_grants + 32'd1;
            if ((state != ST_IDLE) && (!i_empty || !d_empty) && (wait_cycles != 32'hFFFF_FFFF))
                wait_cycles <= wait_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_l2_request_arbiter.sv
// tb/tb_l2_request_arbiter.sv - directed self-checking bench for l2_request_arbiter
module tb_l2_request_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req_valid, d_req_valid, d_req_we;
    logic [25:0] i_req_addr, d_req_addr;
    logic        i_req_ready, d_req_ready;
    logic        l2_valid, l2_we, l2_src, l2_ready, l2_done;
    logic [25:0] l2_addr;
    logic        i_done, d_done, busy;
`ifdef ARB_STATS_EN
    logic [31:0] i_grants, d_grants, wait_cycles;
`endif

    int vectors = 0;
    int miscompares = 0;
    int ip, dp, ic, dc;

    l2_request_arbiter #(.ADDR_W(26), .QDEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
        .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_we(d_req_we),
        .d_req_ready(d_req_ready),
        .l2_valid(l2_valid), .l2_addr(l2_addr), .l2_we(l2_we), .l2_src(l2_src),
        .l2_ready(l2_ready), .l2_done(l2_done),
        .i_done(i_done), .d_done(d_done), .busy(busy)
`ifdef ARB_STATS_EN
        , .i_grants(i_grants), .d_grants(d_grants), .wait_cycles(wait_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        i_req_valid = 1'b0; d_req_valid = 1'b0; d_req_we = 1'b0;
        i_req_addr = '0; d_req_addr = '0; l2_ready = 1'b0; l2_done = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("rst_l2_valid", 32'(l2_valid), 32'd0);
        chk("rst_l2_addr", 32'(l2_addr), 32'd0);
        chk("rst_l2_we", 32'(l2_we), 32'd0);
        chk("rst_l2_src", 32'(l2_src), 32'd0);
        chk("rst_done", {30'd0, i_done, d_done}, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", {30'd0, i_req_ready, d_req_ready}, 32'd3);

        // single I request, L2 handshakes tied high
        l2_ready = 1'b1; l2_done = 1'b1;
        i_req_valid = 1'b1; i_req_addr = 26'h0000123;
        cyc();
        i_req_valid = 1'b0;
        chk("t1_valid_e0", 32'(l2_valid), 32'd0);
        chk("t1_busy_e0", 32'(busy), 32'd1);
        cyc();
        chk("t1_valid_e1", 32'(l2_valid), 32'd1);
        chk("t1_addr_e1", 32'(l2_addr), 32'h123);
        chk("t1_src_we_e1", {30'd0, l2_src, l2_we}, 32'd0);
        cyc();
        chk("t1_valid_e2", 32'(l2_valid), 32'd0);
        chk("t1_idone_e2", 32'(i_done), 32'd0);
        cyc();
        chk("t1_idone_e3", 32'(i_done), 32'd1);
        chk("t1_busy_e3", 32'(busy), 32'd0);
        cyc();
        chk("t1_idone_e4", 32'(i_done), 32'd0);

        // simultaneous I and D pushes: I wins the first tie after reset
        do_reset();
        l2_ready = 1'b1; l2_done = 1'b1;
        i_req_valid = 1'b1; i_req_addr = 26'h0000010;
        d_req_valid = 1'b1; d_req_addr = 26'h0000020; d_req_we = 1'b1;
        cyc();
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        cyc();
        chk("t2_first_addr", 32'(l2_addr), 32'h10);
        chk("t2_first_src", 32'(l2_src), 32'd0);
        cyc();
        cyc();
        chk("t2_idone_first", {30'd0, i_done, d_done}, 32'd2);
        cyc();
        chk("t2_second_valid", 32'(l2_valid), 32'd1);
        chk("t2_second_addr", 32'(l2_addr), 32'h20);
        chk("t2_second_src_we", {30'd0, l2_src, l2_we}, 32'd3);
        cyc();
        cyc();
        chk("t2_ddone", {30'd0, i_done, d_done}, 32'd1);

        // fill the D queue under an L2 stall
        l2_ready = 1'b0; l2_done = 1'b0;
        d_req_valid = 1'b1; d_req_addr = 26'h100; d_req_we = 1'b0;
        cyc();
        d_req_addr = 26'h101; d_req_we = 1'b1;
        cyc();
        chk("t3_full_ready", 32'(d_req_ready), 32'd0);
        chk("t3_head_addr", 32'(l2_addr), 32'h100);
        chk("t3_head_src_we", {30'd0, l2_src, l2_we}, 32'd2);
        d_req_addr = 26'h102; d_req_we = 1'b0;
        cyc();
        d_req_valid = 1'b0;
        chk("t3_still_full", 32'(d_req_ready), 32'd0);
        chk("t3_stall_addr_a", 32'(l2_addr), 32'h100);
        cyc();
        chk("t3_stall_addr_b", 32'(l2_addr), 32'h100);
        chk("t3_stall_valid", 32'(l2_valid), 32'd1);
        l2_ready = 1'b1; l2_done = 1'b1;
        cyc();
        chk("t3_pop_valid", 32'(l2_valid), 32'd0);
        chk("t3_pop_ready", 32'(d_req_ready), 32'd1);
        cyc();
        chk("t3_ddone_a", 32'(d_done), 32'd1);
        cyc();
        chk("t3_second_addr", 32'(l2_addr), 32'h101);
        chk("t3_second_we", 32'(l2_we), 32'd1);
        cyc();
        cyc();
        chk("t3_ddone_b", 32'(d_done), 32'd1);
        chk("t3_refused_busy", 32'(busy), 32'd0);

        // l2_done outside WAIT is ignored
        l2_ready = 1'b0; l2_done = 1'b1;
        cyc();
        cyc();
        chk("t4_idle_done", {30'd0, i_done, d_done}, 32'd0);
        chk("t4_idle_valid", 32'(l2_valid), 32'd0);
        i_req_valid = 1'b1; i_req_addr = 26'h55;
        cyc();
        i_req_valid = 1'b0;
        cyc();
        cyc();
        chk("t4_issue_done", 32'(i_done), 32'd0);
        chk("t4_issue_valid", 32'(l2_valid), 32'd1);
        l2_done = 1'b0; l2_ready = 1'b1;
        cyc();
        chk("t4_wait_valid", 32'(l2_valid), 32'd0);
        cyc();
        chk("t4_wait_nodone", 32'(i_done), 32'd0);
        l2_done = 1'b1;
        cyc();
        chk("t4_idone", 32'(i_done), 32'd1);

        // reset during WAIT; last is I so D wins this tie
        l2_ready = 1'b1; l2_done = 1'b0;
        i_req_valid = 1'b1; i_req_addr = 26'h77;
        d_req_valid = 1'b1; d_req_addr = 26'h88; d_req_we = 1'b1;
        cyc();
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        cyc();
        chk("t5_rr_src", 32'(l2_src), 32'd1);
        chk("t5_rr_addr", 32'(l2_addr), 32'h88);
        cyc();
        chk("t5_wait_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_addr", 32'(l2_addr), 32'd0);
        chk("t5_async_src_we", {30'd0, l2_src, l2_we}, 32'd0);
        chk("t5_async_busy", 32'(busy), 32'd0);
        chk("t5_async_ready", {30'd0, i_req_ready, d_req_ready}, 32'd3);
        l2_done = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t5_late_done", {30'd0, i_done, d_done}, 32'd0);
            chk("t5_post_valid", {30'd0, l2_valid, busy}, 32'd0);
        end

        // sustained traffic: 4 I and 3 D requests
        do_reset();
        l2_ready = 1'b1; l2_done = 1'b1;
        ip = 0; dp = 0; ic = 0; dc = 0;
        for (int c = 0; c < 300 && (ic < 4 || dc < 3); c++) begin
            i_req_valid = (ip < 4);
            i_req_addr  = 26'h200 + 26'(ip);
            d_req_valid = (dp < 3);
            d_req_addr  = 26'h300 + 26'(dp);
            d_req_we    = dp[0];
            if (i_req_valid && i_req_ready) ip++;
            if (d_req_valid && d_req_ready) dp++;
            cyc();
            if (i_done) ic++;
            if (d_done) dc++;
        end
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        chk("t6_i_completions", 32'(ic), 32'd4);
        chk("t6_d_completions", 32'(dc), 32'd3);
        chk("t6_idle_busy", 32'(busy), 32'd0);
`ifdef ARB_STATS_EN
        chk("t6_i_grants", i_grants, 32'd4);
        chk("t6_d_grants", d_grants, 32'd3);
        chk("t6_wait_nonzero", 32'(wait_cycles > 32'd0), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/l2_request_arbiter.md
# l2_request_arbiter

Shares the single next-level (L2) cache port between the instruction cache and the data cache. Each L1 pushes 26-bit line-address miss/write requests into its own small queue; a three-state controller picks one head entry by round-robin, presents it to L2, waits for completion, and pulses a done strobe back to the requester. It sits between the L1 cache blocks and the next-level cache model, with one outstanding L2 transaction at a time.

## Interface
- ADDR_W, 26, line-address width (bits [31:6] of the byte address)
- QDEPTH, 2, entries per requester queue; power of two, 2..8
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_req_valid  in  1  I-cache request present
- i_req_addr  in  ADDR_W  I-cache line address
- i_req_ready  out  1  I-queue not full
- d_req_valid  in  1  D-cache request present
- d_req_addr  in  ADDR_W  D-cache line address
- d_req_we  in  1  D-cache request is a write
- d_req_ready  out  1  D-queue not full
- l2_valid  out  1  request presented to L2
- l2_addr  out  ADDR_W  presented address
- l2_we  out  1  presented write flag (always 0 for I-source)
- l2_src  out  1  0 = I-cache, 1 = D-cache
- l2_ready  in  1  L2 accepts presented request
- l2_done  in  1  L2 completes outstanding request
- i_done, d_done  out  1  one-cycle completion pulse to the owning requester
- busy  out  1  FSM not IDLE or any queue non-empty
- i_grants, d_grants, wait_cycles  out  32  statistics (present only with ARB_STATS_EN)

## Operation
- Push: x_req_valid & x_req_ready at a rising edge writes the entry into that queue. x_req_ready = !full, registered-state based; no bypass, so a full queue refuses a push even in the cycle it pops.
- FSM states IDLE, ISSUE, WAIT.
- IDLE: if either queue non-empty, select source and go ISSUE. Both non-empty: grant the source other than `last`; one non-empty: grant it. Else stay.
- ISSUE: l2_valid=1, l2_addr/l2_we/l2_src driven from selected head; held stable until l2_ready. On l2_valid & l2_ready: pop head, go WAIT.
- WAIT: on l2_done: pulse i_done (src 0) or d_done (src 1) for one cycle, set last=src, go IDLE.
- l2_done outside WAIT is ignored. l2_ready outside ISSUE is ignored.
- Queue pointers are log2(QDEPTH)+1 bits; full when MSBs differ and low bits equal; wrap-around natural.
- Reset values: FSM IDLE, queues empty, last=1 (I-cache wins first tie), l2_valid=0, l2_addr=0, l2_we=0, l2_src=0, i_done=d_done=0, busy=0, x_req_ready=1, all counters 0.

## Timing
- Push accepted at edge E0 into empty queue with FSM IDLE: FSM enters ISSUE at E1; l2_valid high in the cycle after E1.
- l2_ready sampled high at edge Ek: l2_valid low after Ek (WAIT).
- l2_done sampled high at edge Em: done pulse high for exactly the cycle after Em; FSM IDLE; next l2_valid earliest after Em+1.
- Minimum per-request turnaround: 3 cycles with l2_ready and l2_done each asserted in the first eligible cycle.
- All outputs registered; no combinational path from inputs to outputs except none (x_req_ready from queue state only).
- Reset asserted mid-transaction: everything returns to reset values asynchronously; the in-flight L2 request is abandoned; a late l2_done after reset release is ignored (FSM IDLE).

## Configuration
- ARB_STATS_EN defined: i_grants/d_grants increment on each l2_valid & l2_ready handshake by source; wait_cycles increments every cycle a queue is non-empty but the FSM is not in IDLE selecting it (i.e. any non-empty queue while FSM in ISSUE or WAIT). Counters saturate at 32'hFFFF_FFFF; cleared only by reset.
- Not defined: the three ports and counters are absent; arbitration behaviour identical.

## Test plan
- Single I request 0x0000123 into idle block, l2_ready and l2_done tied high -> l2_valid one cycle after acceptance with l2_src=0, l2_we=0, i_done pulse 3 cycles after acceptance, busy back to 0.
- I and D both push in the same cycle (I 0x0000010, D 0x0000020 we=1) -> I granted first (last=1 at reset), then D with l2_we=1; i_done precedes d_done.
- Fill D-queue with 2 entries while L2 holds l2_ready=0 -> d_req_ready=0; third push refused; l2_addr stable through stall; entries drain in FIFO order.
- Spurious l2_done in IDLE and ISSUE -> no done pulse, no state change.
- Assert rst_n=0 during WAIT -> all outputs reset immediately; l2_done after release produces no pulse; queues empty.
- With ARB_STATS_EN: 4 I and 3 D requests completed -> i_grants=4, d_grants=3, wait_cycles > 0 when both queues contended.
